// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit-side control blocks:
// arbiter FSM encoding, timeout defaults and small index helpers.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_LOW  = 2'd2,
    S_WAIT_HIGH = 2'd3
  } state_t;

  localparam int ACK_TIMEOUT_DEF = 7;
  localparam int TMO_W           = 3;
  localparam int ID_W            = 3;

  // Next requester index with wrap at n.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id, input int n);
    if (int'(id) >= n - 1) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: first set request at or above i_ptr, wrapping.
// Purely combinational.
module rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_idx
);

  logic            w_found;
  logic [ID_W-1:0] w_idx;

  // Outer loop is priority distance from the pointer; inner loop finds the
  // requester at that distance, covering the wrapped case with +NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && i_req[j] &&
            ((int'(i_ptr) + k == j) || (int'(i_ptr) + k == j + NUM_REQ))) begin
          w_found = 1'b1;
          w_idx   = ID_W'(j);
        end
      end
    end
  end

  assign o_valid = w_found;
  assign o_idx   = w_idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte sources onto one UART transmitter holding register,
// with optional per-packet grant lock and a stuck-transmitter watchdog.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter bit PKT_LOCK    = 1'b1,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_req_last,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_ack,
  input  logic                 i_tx_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_load,
  output logic [2:0]           o_grant_id,
  output logic                 o_busy,
  output logic                 o_err_stuck,
  input  logic                 i_err_clr
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  // Minimum cycles since the load before WAIT_HIGH may act; keeps
  // load-to-load spacing at 4 even when tx_ready is low for a single cycle.
  localparam logic [TMO_W-1:0] HIGH_MIN = TMO_W'(2);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_grant;
  logic              r_lock;
  logic [7:0]        r_tx_data;
  logic              r_err;
  logic [TMO_W-1:0]  r_tmo;

  logic              w_pick_vld;
  logic [ID_W-1:0]   w_pick_idx;
  logic              w_gnt_req;
  logic              w_gnt_last;
  logic [7:0]        w_gnt_dat;
  logic              w_fire;
  logic              w_take_grant;
  logic              w_lock_clr;
  logic              w_rr_adv;
  logic              w_err_set;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_gnt_req  = 1'b0;
    w_gnt_last = 1'b0;
    w_gnt_dat  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == ID_W'(i)) begin
        w_gnt_req  = i_req[i];
        w_gnt_last = i_req_last[i];
        w_gnt_dat  = i_req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fire       = 1'b0;
    w_take_grant = 1'b0;
    w_lock_clr   = 1'b0;
    w_rr_adv     = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_tx_ready && w_pick_vld) begin
          w_take_grant = 1'b1;
          w_state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        // A requester that withdrew (or a transmitter not ready) aborts the load.
        if (w_gnt_req && i_tx_ready) begin
          w_fire      = 1'b1;
          w_state_nxt = S_WAIT_LOW;
        end else begin
          w_lock_clr  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_LOW: begin
        if (!i_tx_ready) begin
          w_state_nxt = S_WAIT_HIGH;
        end else if (r_tmo == TMO_LAST) begin
          w_err_set   = 1'b1;
          w_lock_clr  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_HIGH: begin
        if (i_tx_ready && r_tmo >= HIGH_MIN) begin
          if (r_lock && w_gnt_req) begin
            w_state_nxt = S_LOAD;
          end else if (!r_lock) begin
            w_rr_adv    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_lock    <= 1'b0;
      r_tx_data <= '0;
      r_err     <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take_grant) begin
        r_grant <= w_pick_idx;
      end
      if (w_fire) begin
        r_tx_data <= w_gnt_dat;
        r_lock    <= PKT_LOCK & ~w_gnt_last;
      end else if (w_lock_clr || w_rr_adv) begin
        r_lock <= 1'b0;
      end
      if (w_rr_adv) begin
        r_rr_ptr <= wrap_inc(r_grant, NUM_REQ);
      end
      // LOAD always precedes WAIT_LOW, so clearing here resets it on entry.
      if (r_state == S_LOAD) begin
        r_tmo <= '0;
      end else if (r_tmo != '1) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  always_comb begin
    o_ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_fire && r_grant == ID_W'(i)) begin
        o_ack[i] = 1'b1;
      end
    end
  end

  assign o_tx_load   = w_fire;
  assign o_tx_data   = w_fire ? w_gnt_dat : r_tx_data;
  assign o_grant_id  = r_grant;
  assign o_busy      = (r_state != S_IDLE);
  assign o_err_stuck = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: a packet-locked and an unlocked arbiter driven side by side
// from the same byte queues, each with its own transmitter model.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             aresetn;
  logic             err_clr;
  logic [N-1:0]     req      [2];
  logic [N-1:0]     req_last [2];
  logic [8*N-1:0]   req_data [2];
  logic [N-1:0]     ack      [2];
  logic             tx_ready [2];
  logic [7:0]       tx_data  [2];
  logic             tx_load  [2];
  logic [2:0]       grant_id [2];
  logic             busy     [2];
  logic             err_stuck[2];

  uart_tx_arbiter #(.NUM_REQ(N), .PKT_LOCK(1'b1), .ACK_TIMEOUT(7)) u_dut_lock (
    .clk(clk), .aresetn(aresetn), .i_req(req[0]), .i_req_last(req_last[0]),
    .i_req_data(req_data[0]), .o_ack(ack[0]), .i_tx_ready(tx_ready[0]),
    .o_tx_data(tx_data[0]), .o_tx_load(tx_load[0]), .o_grant_id(grant_id[0]),
    .o_busy(busy[0]), .o_err_stuck(err_stuck[0]), .i_err_clr(err_clr)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .PKT_LOCK(1'b0), .ACK_TIMEOUT(7)) u_dut_nolock (
    .clk(clk), .aresetn(aresetn), .i_req(req[1]), .i_req_last(req_last[1]),
    .i_req_data(req_data[1]), .o_ack(ack[1]), .i_tx_ready(tx_ready[1]),
    .o_tx_data(tx_data[1]), .o_tx_load(tx_load[1]), .o_grant_id(grant_id[1]),
    .o_busy(busy[1]), .o_err_stuck(err_stuck[1]), .i_err_clr(err_clr)
  );

  // Requester byte queues; each DUT consumes its own copy via ack.
  logic [7:0] q_dat [N][4];
  logic       q_lst [N][4];
  int         q_cnt [N];
  int         q_idx [2][N];
  logic       q_clr;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        if (q_clr) q_idx[d][i] <= 0;
        else if (ack[d][i]) q_idx[d][i] <= q_idx[d][i] + 1;
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        req[d][i]           = (q_idx[d][i] < q_cnt[i]);
        req_last[d][i]      = q_lst[i][q_idx[d][i] % 4];
        req_data[d][8*i +: 8] = q_dat[i][q_idx[d][i] % 4];
      end
    end
  end

  // Transmitter: ready drops after a load for 'hold' cycles; 'stuck' pins it high.
  logic tx_rdy_m [2] = '{1'b1, 1'b1};
  int   tx_cnt   [2] = '{0, 0};
  int   hold;
  logic stuck;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (tx_load[d]) begin
        tx_rdy_m[d] <= 1'b0;
        tx_cnt[d]   <= hold;
      end else if (tx_cnt[d] > 1) begin
        tx_cnt[d] <= tx_cnt[d] - 1;
      end else if (tx_cnt[d] == 1) begin
        tx_rdy_m[d] <= 1'b1;
        tx_cnt[d]   <= 0;
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) tx_ready[d] = stuck | tx_rdy_m[d];
  end

  // Load log plus protocol-violation counter (ack/load coincidence, spacing, ready).
  logic [7:0] lk_dat[$];
  logic [2:0] lk_gid[$];
  logic [N-1:0] lk_ack[$];
  logic [7:0] nl_dat[$];
  logic [2:0] nl_gid[$];
  int viol = 0;
  int cyc = 0;
  int last_ld [2] = '{-100, -100};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (ack[d] != (tx_load[d] ? (N'(1) << grant_id[d]) : N'(0))) viol <= viol + 1;
      if (tx_load[d]) begin
        if (!tx_ready[d] || (cyc - last_ld[d]) < 4) viol <= viol + 1;
        last_ld[d] <= cyc;
      end
    end
    if (tx_load[0]) begin
      lk_dat.push_back(tx_data[0]); lk_gid.push_back(grant_id[0]); lk_ack.push_back(ack[0]);
    end
    if (tx_load[1]) begin
      nl_dat.push_back(tx_data[1]); nl_gid.push_back(grant_id[1]);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lsz(input int d);
    return (d == 0) ? lk_dat.size() : nl_dat.size();
  endfunction
  function automatic logic [7:0] ldat(input int d, input int j);
    return (d == 0) ? lk_dat[j] : nl_dat[j];
  endfunction
  function automatic logic [2:0] lgid(input int d, input int j);
    return (d == 0) ? lk_gid[j] : nl_gid[j];
  endfunction

  task automatic wait_loads(input int n0, input int n1, input string tag);
    int k = 0;
    while ((lsz(0) < n0 || lsz(1) < n1) && k < 3000) begin
      @(negedge clk); k++;
    end
    check({tag, "_loads"}, 32'(lsz(0) >= n0 && lsz(1) >= n1), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!(!busy[0] && !busy[1] && tx_ready[0] && tx_ready[1]) && k < 3000) begin
      @(negedge clk); k++;
    end
    check({tag, "_idle"}, 32'(!busy[0] && !busy[1]), 32'd1);
  endtask

  task automatic wait_load0(input string tag);
    int k = 0;
    while (!tx_load[0] && k < 200) begin
      @(negedge clk); k++;
    end
    check({tag, "_seen"}, 32'(tx_load[0]), 32'd1);
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) q_cnt[i] = 0;
    q_clr = 1'b1;
    @(negedge clk);
    q_clr = 1'b0;
  endtask

  task automatic put(input int i, input logic [7:0] dat, input logic last);
    q_dat[i][q_cnt[i]] = dat;
    q_lst[i][q_cnt[i]] = last;
    q_cnt[i]++;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_rst(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_tx_load"}, 32'(tx_load[d]), 32'd0);
      check({tag, "_ack"}, 32'(ack[d]), 32'd0);
      check({tag, "_busy"}, 32'(busy[d]), 32'd0);
      check({tag, "_err"}, 32'(err_stuck[d]), 32'd0);
      check({tag, "_gid"}, 32'(grant_id[d]), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data[d]), 32'h00);
    end
  endtask

  initial begin
    int b0;
    int b1;
    logic [7:0] exp_lk [4];
    logic [7:0] exp_nl [4];
    aresetn = 1'b0; err_clr = 1'b0; stuck = 1'b0; hold = 2; q_clr = 1'b1;
    for (int i = 0; i < N; i++) begin
      q_cnt[i] = 0;
      for (int k = 0; k < 4; k++) begin q_dat[i][k] = 8'h00; q_lst[i][k] = 1'b0; end
    end
    repeat (3) @(negedge clk);
    q_clr = 1'b0;
    check_rst("reset");
    aresetn = 1'b1;
    @(negedge clk);

    // Single byte from requester 0, ready low for one cycle after load.
    hold = 1;
    clear_q();
    put(0, 8'h55, 1'b1);
    wait_loads(1, 1, "single");
    wait_idle("single");
    repeat (3) @(negedge clk);
    check("single_count", 32'(lk_dat.size()), 32'd1);
    check("single_data", 32'(lk_dat[0]), 32'h55);
    check("single_ack", 32'(lk_ack[0]), 32'h1);
    check("single_acks_seen", 32'(q_idx[0][0]), 32'd1);

    // Round robin from a fresh pointer: 0,1,2,3,0,1,2,3.
    do_reset();
    hold = 2;
    clear_q();
    b0 = lsz(0); b1 = lsz(1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) put(i, 8'((k << 4) | i), 1'b1);
    wait_loads(b0 + 8, b1 + 8, "rr");
    wait_idle("rr");
    for (int j = 0; j < 8; j++) begin
      check("rr_lk_gid", 32'(lgid(0, b0 + j)), 32'(j % 4));
      check("rr_lk_dat", 32'(ldat(0, b0 + j)), 32'(((j / 4) << 4) | (j % 4)));
      check("rr_nl_gid", 32'(lgid(1, b1 + j)), 32'(j % 4));
    end

    // Packet lock: move pointer to 2 via one byte from requester 1, then race 2 vs 0.
    do_reset();
    clear_q();
    put(1, 8'h11, 1'b1);
    b0 = lsz(0); b1 = lsz(1);
    wait_loads(b0 + 1, b1 + 1, "pre_lock");
    wait_idle("pre_lock");
    clear_q();
    b0 = lsz(0); b1 = lsz(1);
    put(2, 8'hA1, 1'b0); put(2, 8'hA2, 1'b0); put(2, 8'hA3, 1'b1);
    put(0, 8'h0B, 1'b1);
    wait_loads(b0 + 4, b1 + 4, "lock");
    wait_idle("lock");
    exp_lk = '{8'hA1, 8'hA2, 8'hA3, 8'h0B};
    exp_nl = '{8'hA1, 8'h0B, 8'hA2, 8'hA3};
    for (int j = 0; j < 4; j++) begin
      check("lock_order", 32'(ldat(0, b0 + j)), 32'(exp_lk[j]));
      check("nolock_order", 32'(ldat(1, b1 + j)), 32'(exp_nl[j]));
    end

    // Stuck transmitter: error after 7 WAIT_LOW cycles, set beats clear, clear works.
    do_reset();
    stuck = 1'b1;
    clear_q();
    put(0, 8'h5A, 1'b1);
    wait_load0("stuck1");
    repeat (7) @(negedge clk);
    check("stuck_before_err", 32'(err_stuck[0]), 32'd0);
    check("stuck_before_busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    check("stuck_err_lk", 32'(err_stuck[0]), 32'd1);
    check("stuck_err_nl", 32'(err_stuck[1]), 32'd1);
    check("stuck_idle", 32'(busy[0]), 32'd0);
    clear_q();
    put(0, 8'h5B, 1'b1);
    wait_load0("stuck2");
    repeat (7) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("set_wins_lk", 32'(err_stuck[0]), 32'd1);
    check("set_wins_nl", 32'(err_stuck[1]), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", 32'(err_stuck[0]), 32'd0);
    stuck = 1'b0;
    wait_idle("stuck");

    // Reset during WAIT_HIGH of a locked packet, then requester 0 wins first.
    do_reset();
    hold = 10;
    clear_q();
    b0 = lsz(0); b1 = lsz(1);
    put(2, 8'hA1, 1'b0); put(2, 8'hA2, 1'b0); put(2, 8'hA3, 1'b1);
    wait_loads(b0 + 1, b1 + 1, "rst_mid");
    repeat (3) @(negedge clk);
    check("rst_mid_busy", 32'(busy[0]), 32'd1);
    aresetn = 1'b0;
    #1;
    check_rst("rst_mid");
    clear_q();
    put(2, 8'hC2, 1'b1);
    put(0, 8'hC0, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_hold_loads", 32'(lsz(0)), 32'(b0 + 1));
    aresetn = 1'b1;
    hold = 2;
    wait_loads(b0 + 3, b1 + 3, "rst_after");
    wait_idle("rst_after");
    check("rst_first_lk", 32'(ldat(0, b0 + 1)), 32'hC0);
    check("rst_first_gid", 32'(lgid(0, b0 + 1)), 32'd0);
    check("rst_second_lk", 32'(ldat(0, b0 + 2)), 32'hC2);
    check("rst_first_nl", 32'(ldat(1, b1 + 1)), 32'hC0);

    check("protocol_violations", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
